// File: rtl/btn_pulse_gen.sv
// Push-button conditioning: two-flop synchroniser, tick-sampled debounce,
// single-cycle press pulses and optional hold-to-repeat pulses per channel.
module btn_pulse_gen #(
  parameter int unsigned N_BTN        = 3,
  parameter int unsigned SAMPLE_DIV   = 1250000,
  parameter int unsigned ACTIVE_LOW   = 1,
  parameter int unsigned REPEAT_EN    = 0,
  parameter int unsigned HOLD_TICKS   = 20,
  parameter int unsigned REPEAT_TICKS = 4
) (
  input  logic             CLOCK_50,
  input  logic             RST_N,
  input  logic [N_BTN-1:0] BTN_RAW,
  output logic [N_BTN-1:0] LEVEL,
  output logic [N_BTN-1:0] PULSE,
  output logic             TICK
);

  localparam int unsigned      PW      = $clog2(SAMPLE_DIV);
  localparam logic [PW-1:0]    PMAX    = PW'(SAMPLE_DIV - 1);
  localparam logic [N_BTN-1:0] REL_RAW = (ACTIVE_LOW != 0) ? {N_BTN{1'b1}} : {N_BTN{1'b0}};

  logic [PW-1:0]    presc_q, presc_d;
  logic             tick;
  logic [N_BTN-1:0] meta_q, sync_q;
  logic [N_BTN-1:0] sample_q;
  logic [N_BTN-1:0] level_q, level_d;
  logic [N_BTN-1:0] pulse_q, pulse_d;
  logic [N_BTN-1:0] pressed, upd, press_edge, rep_pulse;

  assign tick = (presc_q == PMAX);

  // A channel follows its input only when this tick's sample matches the previous one.
  always_comb begin
    presc_d    = tick ? '0 : presc_q + PW'(1);
    pressed    = sync_q ^ REL_RAW;
    upd        = {N_BTN{tick}} & ~(sample_q ^ pressed) & (pressed ^ level_q);
    level_d    = (level_q & ~upd) | (pressed & upd);
    press_edge = upd & pressed;
    pulse_d    = press_edge | rep_pulse;
  end

  always_ff @(posedge CLOCK_50 or negedge RST_N) begin
    if (!RST_N) begin
      presc_q  <= '0;
      meta_q   <= REL_RAW;
      sync_q   <= REL_RAW;
      sample_q <= '0;
      level_q  <= '0;
      pulse_q  <= '0;
    end else begin
      presc_q <= presc_d;
      meta_q  <= BTN_RAW;
      sync_q  <= meta_q;
      if (tick) sample_q <= pressed;
      level_q <= level_d;
      pulse_q <= pulse_d;
    end
  end

  if (REPEAT_EN != 0) begin : g_rep
    localparam int unsigned   CW   = $clog2(HOLD_TICKS + 1);
    localparam logic [CW-1:0] HMAX = CW'(HOLD_TICKS - 1);
    localparam logic [CW-1:0] RLD  = CW'((REPEAT_TICKS >= HOLD_TICKS) ? 0 : HOLD_TICKS - REPEAT_TICKS);

    for (genvar g = 0; g < N_BTN; g++) begin : g_ch
      logic [CW-1:0] hold_q, hold_d;
      logic          rp;

      // Counter holds ticks-held minus one reload period, so it tops out below HOLD_TICKS.
      always_comb begin
        hold_d = hold_q;
        rp     = 1'b0;
        if (!level_d[g] || press_edge[g]) begin
          hold_d = '0;
        end else if (tick) begin
          if (hold_q == HMAX) begin
            rp     = 1'b1;
            hold_d = RLD;
          end else begin
            hold_d = hold_q + CW'(1);
          end
        end
      end

      always_ff @(posedge CLOCK_50 or negedge RST_N) begin
        if (!RST_N) hold_q <= '0;
        else        hold_q <= hold_d;
      end

      assign rep_pulse[g] = rp;
    end
  end else begin : g_norep
    assign rep_pulse = '0;
  end

  assign LEVEL = level_q;
  assign PULSE = pulse_q;
  assign TICK  = tick;

endmodule
